// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory responder and its lane aligner.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the EX address path (master) and the data memory (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );

endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: load extraction, store lane placement, byte enables, alignment check.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic        align_fault
);

    // be[i] selects byte offset i, which lives in rword/wword bits 31-8*i -: 8
    always_comb begin
        load_word   = '0;
        be          = '0;
        wword       = '0;
        align_fault = 1'b0;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    load_word = {24'h0, rword[31:24]};
                    2'd1:    load_word = {24'h0, rword[23:16]};
                    2'd2:    load_word = {24'h0, rword[15:8]};
                    default: load_word = {24'h0, rword[7:0]};
                endcase
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                align_fault = addr_lo[0];
                load_word   = addr_lo[1] ? {16'h0, rword[15:0]} : {16'h0, rword[31:16]};
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword       = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                align_fault = (addr_lo != 2'b00);
                load_word   = rword;
                be          = 4'b1111;
                wword       = wdata;
            end
            default: align_fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle byte-addressed data memory: one request at a time, programmable wait, one response pulse.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_responder_if.slave bus,
    output logic               busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [7:0]       mem [DEPTH];
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_write;
    logic [1:0]       lat_size;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;

    logic [ADDR_W-1:0] base;
    logic [31:0]       rword;
    logic [31:0]       load_word;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic              align_fault;
    logic              range_fault;
    logic              fault;
    logic              do_access;

    assign base        = {lat_addr[ADDR_W-1:2], 2'b00};
    assign rword       = {mem[base], mem[base | ADDR_W'(1)],
                          mem[base | ADDR_W'(2)], mem[base | ADDR_W'(3)]};
    assign range_fault = ((lat_addr >> ADDR_W) != 32'h0);
    assign fault       = align_fault | range_fault;
    assign do_access   = (state == ST_WAIT) && (cnt == '0);

    mem_lane_align u_align (
        .size        (lat_size),
        .addr_lo     (lat_addr[1:0]),
        .rword       (rword),
        .wdata       (lat_wdata),
        .load_word   (load_word),
        .be          (be),
        .wword       (wword),
        .align_fault (align_fault)
    );

    // Array write happens only on the access edge; reset on that edge suppresses it
    always_ff @(posedge clk) begin
        if (!reset && do_access && lat_write && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[base | ADDR_W'(i)] <= wword[31-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            lat_write      <= 1'b0;
            lat_size       <= SZ_BYTE;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_fault <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_write     <= bus.req_write;
                        lat_size      <= bus.req_size;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        cnt           <= CNT_W'(WAIT_CYCLES);
                        state         <= ST_WAIT;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        bus.resp_rdata <= (fault || lat_write) ? 32'h0 : load_word;
                        bus.resp_fault <= fault;
                        bus.resp_valid <= 1'b1;
                        state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: begin
                    state          <= ST_IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule
